// File: rtl/cr_xp10_decomp_mtf_resolve.sv
// cr_xp10_decomp_mtf_resolve
// Resolves XP10 move-to-front pointer references against a 4-entry
// recent-offset history. Every MTF pointer is rewritten to a plain pointer
// that carries the real offset. One symbol per cycle, registered outputs and
// a 2-entry skid buffer. Input ready depends only on skid occupancy.
// mtf_stb is registered on the accepting clock edge and lasts one cycle,
// whatever the downstream stall state.
// Build option: CR_XP10_DECOMP_MTF_ERR_STICKY_EN makes out_err sticky until
// an end-of-frame EOB has been output. Without it, out_err flags only the
// offending symbol.
module cr_xp10_decomp_mtf_resolve #(
  parameter int unsigned HIST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdd_mtf_dp_valid,
  output logic        sdd_mtf_dp_ready,
  input  logic [1:0]  in_type,
  input  logic [7:0]  in_lit,
  input  logic [15:0] in_len,
  input  logic [15:0] in_ofs,
  input  logic        in_eof,
  output logic        mtf_out_valid,
  input  logic        mtf_out_ready,
  output logic [1:0]  out_type,
  output logic [7:0]  out_lit,
  output logic [15:0] out_len,
  output logic [15:0] out_ofs,
  output logic        out_eof,
  output logic        out_err,
  output logic [3:0]  mtf_stb
);

  localparam int unsigned OFS_W = 16;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned LIT_W = 8;
  localparam int unsigned IDX_W = $clog2(HIST_DEPTH);
  localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1);

  localparam logic [1:0] SYM_LIT = 2'd0;
  localparam logic [1:0] SYM_PTR = 2'd1;
  localparam logic [1:0] SYM_MTF = 2'd2;
  localparam logic [1:0] SYM_EOB = 2'd3;

  typedef struct packed {
    logic [1:0]       typ;
    logic [LIT_W-1:0] lit;
    logic [LEN_W-1:0] len;
    logic [OFS_W-1:0] ofs;
    logic             eof;
    logic             err;
  } sym_t;

  logic [OFS_W-1:0]      hist_q [HIST_DEPTH];
  logic [OFS_W-1:0]      hist_d [HIST_DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HIST_DEPTH-1:0] stb_q, stb_d;
  sym_t                  out_q, skid_q, res, res_fin;
  logic                  out_vld_q, skid_vld_q;
  logic                  accept, pop;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  mv_en;
  logic [IDX_W-1:0]      mv_idx;
  logic [OFS_W-1:0]      mv_ofs;
  logic [IDX_W-1:0]      mtf_idx;
  logic                  mtf_err;
  logic                  clr;
  logic                  res_err;

  assign accept  = sdd_mtf_dp_valid && !skid_vld_q;
  assign pop     = out_vld_q && mtf_out_ready;
  assign mtf_idx = in_ofs[IDX_W-1:0];

  // Locate the populated history slot that matches an incoming pointer offset
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_q) && (hist_q[i] == in_ofs)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Resolve the accepted symbol and compute the next history state
  always_comb begin
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    stb_d   = '0;
    mv_en   = 1'b0;
    mv_idx  = '0;
    mv_ofs  = '0;
    mtf_err = 1'b0;
    clr     = 1'b0;
    res     = '{typ: in_type, lit: in_lit, len: in_len, ofs: in_ofs, eof: in_eof, err: 1'b0};
    case (in_type)
      SYM_PTR: begin
        // a miss behaves like moving the last slot forward, dropping the oldest entry
        mv_en  = 1'b1;
        mv_ofs = in_ofs;
        mv_idx = hit ? hit_idx : IDX_W'(HIST_DEPTH - 1);
        if (!hit && (cnt_q != CNT_W'(HIST_DEPTH))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SYM_MTF: begin
        res.typ = SYM_PTR;
        if ({1'b0, mtf_idx} < cnt_q) begin
          res.ofs         = hist_q[mtf_idx];
          mv_en           = 1'b1;
          mv_idx          = mtf_idx;
          mv_ofs          = hist_q[mtf_idx];
          stb_d[mtf_idx]  = 1'b1;
        end else begin
          res.ofs = '0;
          mtf_err = 1'b1;
        end
      end
      SYM_EOB: clr = in_eof;
      default: ;
    endcase
    if (mv_en) begin
      hist_d[0] = mv_ofs;
      for (int unsigned j = 1; j < HIST_DEPTH; j++) begin
        if (IDX_W'(j) <= mv_idx) begin
          hist_d[j] = hist_q[j-1];
        end
      end
    end
    if (clr) begin
      for (int unsigned j = 0; j < HIST_DEPTH; j++) begin
        hist_d[j] = '0;
      end
      cnt_d = '0;
    end
    if (!accept) begin
      hist_d = hist_q;
      cnt_d  = cnt_q;
      stb_d  = '0;
    end
  end

`ifdef CR_XP10_DECOMP_MTF_ERR_STICKY_EN
  logic err_sticky_q, err_sticky_d;

  // Frame-level error flag: set by a bad MTF index, cleared by an EOF EOB
  always_comb begin
    err_sticky_d = err_sticky_q;
    res_err      = mtf_err || err_sticky_q;
    if (accept) begin
      if ((in_type == SYM_EOB) && in_eof) begin
        err_sticky_d = 1'b0;
      end else if (mtf_err) begin
        err_sticky_d = 1'b1;
      end
    end
  end

  // Sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end
`else
  // Error flags only the offending symbol
  always_comb begin
    res_err = mtf_err;
  end
`endif

  // Attach the error flag to the resolved symbol
  always_comb begin
    res_fin     = res;
    res_fin.err = res_err;
  end

  // History and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < HIST_DEPTH; j++) begin
        hist_q[j] <= '0;
      end
      cnt_q <= '0;
      stb_q <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      stb_q  <= stb_d;
    end
  end

  // Output register plus skid register; the skid drains into the output first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (skid_vld_q) begin
      if (pop) begin
        out_q      <= skid_q;
        skid_vld_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_vld_q || pop) begin
        out_q     <= res_fin;
        out_vld_q <= 1'b1;
      end else begin
        skid_q     <= res_fin;
        skid_vld_q <= 1'b1;
      end
    end else if (pop) begin
      out_vld_q <= 1'b0;
    end
  end

  assign sdd_mtf_dp_ready = !skid_vld_q;
  assign mtf_out_valid    = out_vld_q;
  assign out_type         = out_q.typ;
  assign out_lit          = out_q.lit;
  assign out_len          = out_q.len;
  assign out_ofs          = out_q.ofs;
  assign out_eof          = out_q.eof;
  assign out_err          = out_q.err;
  assign mtf_stb          = stb_q;

endmodule
